// File: rtl/argmax_pkg.sv
// rtl/argmax_pkg.sv - shared types and helpers for the streaming argmax unit
package argmax_pkg;

    // Two-phase controller: collect beats, then present the result.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    // Common compare width; scores up to 64 bits are extended into it.
    localparam int GT_W = 65;

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Strict greater-than on pre-extended operands, signed or unsigned.
    function automatic logic gt(input logic [GT_W-1:0] a,
                                input logic [GT_W-1:0] b,
                                input logic            signed_mode);
        logic r;
        if (signed_mode) begin
            r = $signed(a) > $signed(b);
        end else begin
            r = a > b;
        end
        return r;
    endfunction

endpackage

// File: rtl/argmax_step.sv
// rtl/argmax_step.sv - one combinational compare/update cell of the argmax chain (runner-up fields under STREAM_ARGMAX_MARGIN_EN)
module argmax_step
    import argmax_pkg::*;
#(
    parameter int VALUE_WIDTH = 32,
    parameter int IDX_W       = 4,
    parameter bit SIGNED      = 1'b0
) (
    input  logic                   en_i,
    input  logic                   first_i,
    input  logic [VALUE_WIDTH-1:0] cand_value_i,
    input  logic [IDX_W-1:0]       cand_index_i,
    input  logic [VALUE_WIDTH-1:0] max_value_i,
    input  logic [IDX_W-1:0]       max_index_i,
`ifdef STREAM_ARGMAX_MARGIN_EN
    input  logic                   sec_valid_i,
    input  logic [VALUE_WIDTH-1:0] sec_value_i,
    input  logic [IDX_W-1:0]       sec_index_i,
    output logic                   sec_valid_o,
    output logic [VALUE_WIDTH-1:0] sec_value_o,
    output logic [IDX_W-1:0]       sec_index_o,
`endif
    output logic [VALUE_WIDTH-1:0] max_value_o,
    output logic [IDX_W-1:0]       max_index_o
);

    function automatic logic [GT_W-1:0] ext(input logic [VALUE_WIDTH-1:0] v);
        return SIGNED ? {{(GT_W-VALUE_WIDTH){v[VALUE_WIDTH-1]}}, v}
                      : {{(GT_W-VALUE_WIDTH){1'b0}}, v};
    endfunction

    logic beats_max;
    assign beats_max = gt(ext(cand_value_i), ext(max_value_i), SIGNED);

`ifdef STREAM_ARGMAX_MARGIN_EN
    logic beats_sec;
    assign beats_sec = gt(ext(cand_value_i), ext(sec_value_i), SIGNED);
`endif

    // Fold one candidate into the running max (and runner-up); strict compare keeps the lowest index on ties.
    always_comb begin
        max_value_o = max_value_i;
        max_index_o = max_index_i;
`ifdef STREAM_ARGMAX_MARGIN_EN
        sec_valid_o = sec_valid_i;
        sec_value_o = sec_value_i;
        sec_index_o = sec_index_i;
`endif
        if (en_i) begin
            if (first_i) begin
                max_value_o = cand_value_i;
                max_index_o = cand_index_i;
`ifdef STREAM_ARGMAX_MARGIN_EN
                sec_valid_o = 1'b0;
`endif
            end else if (beats_max) begin
`ifdef STREAM_ARGMAX_MARGIN_EN
                sec_valid_o = 1'b1;
                sec_value_o = max_value_i;
                sec_index_o = max_index_i;
`endif
                max_value_o = cand_value_i;
                max_index_o = cand_index_i;
            end
`ifdef STREAM_ARGMAX_MARGIN_EN
            else if (!sec_valid_i || beats_sec) begin
                sec_valid_o = 1'b1;
                sec_value_o = cand_value_i;
                sec_index_o = cand_index_i;
            end
`endif
        end
    end

endmodule

// File: rtl/stream_argmax.sv
// rtl/stream_argmax.sv - streaming multi-lane argmax with registered result handshake (optional runner-up/margin via STREAM_ARGMAX_MARGIN_EN)
module stream_argmax
    import argmax_pkg::*;
#(
    parameter int  VALUE_WIDTH = 32,
    parameter int  NUM_VALUES  = 10,
    parameter int  LANES       = 2,
    parameter int  SIGNED      = 0,
    localparam int IDX_W       = idx_w(NUM_VALUES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*VALUE_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_index,
    output logic [VALUE_WIDTH-1:0]       out_value
`ifdef STREAM_ARGMAX_MARGIN_EN
    ,
    output logic [IDX_W-1:0]             out_second_index,
    output logic [VALUE_WIDTH:0]         out_margin
`endif
);

    localparam int NUM_BEATS = (NUM_VALUES + LANES - 1) / LANES;
    localparam int CNT_W     = idx_w(NUM_BEATS);
    localparam bit SGN       = (SIGNED != 0);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic [VALUE_WIDTH-1:0] run_value_q, run_value_d;
    logic [IDX_W-1:0]       run_index_q, run_index_d;
    logic [VALUE_WIDTH-1:0] res_value_q, res_value_d;
    logic [IDX_W-1:0]       res_index_q, res_index_d;

    logic accept;
    logic last_beat;

    // Chain taps: entry 0 is the running state, entry k+1 the state after lane k.
    logic [VALUE_WIDTH-1:0] chain_value [LANES+1];
    logic [IDX_W-1:0]       chain_index [LANES+1];

`ifdef STREAM_ARGMAX_MARGIN_EN
    logic                   run_sec_valid_q, run_sec_valid_d;
    logic [VALUE_WIDTH-1:0] run_sec_value_q, run_sec_value_d;
    logic [IDX_W-1:0]       run_sec_index_q, run_sec_index_d;
    logic [IDX_W-1:0]       res_sec_index_q, res_sec_index_d;
    logic [VALUE_WIDTH:0]   res_margin_q, res_margin_d;
    logic [VALUE_WIDTH:0]   margin_calc;

    logic                   chain_sec_valid [LANES+1];
    logic [VALUE_WIDTH-1:0] chain_sec_value [LANES+1];
    logic [IDX_W-1:0]       chain_sec_index [LANES+1];

    function automatic logic [VALUE_WIDTH:0] ext1(input logic [VALUE_WIDTH-1:0] v);
        return SGN ? {v[VALUE_WIDTH-1], v} : {1'b0, v};
    endfunction

    assign chain_sec_valid[0] = run_sec_valid_q;
    assign chain_sec_value[0] = run_sec_value_q;
    assign chain_sec_index[0] = run_sec_index_q;

    // Runner-up never exceeds the max, so this difference is non-negative.
    assign margin_calc = ext1(chain_value[LANES]) - ext1(chain_sec_value[LANES]);
`endif

    assign chain_value[0] = run_value_q;
    assign chain_index[0] = run_index_q;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_q == CNT_W'(NUM_BEATS - 1));

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            logic [31:0] lane_pos;
            logic        lane_en;
            logic        lane_first;

            // Padding lanes past the end of the vector are masked out.
            assign lane_pos   = 32'(beat_q) * 32'(LANES) + 32'(k);
            assign lane_en    = lane_pos < 32'(NUM_VALUES);
            assign lane_first = (k == 0) && (beat_q == '0);

            argmax_step #(
                .VALUE_WIDTH (VALUE_WIDTH),
                .IDX_W       (IDX_W),
                .SIGNED      (SGN)
            ) u_step (
                .en_i         (lane_en),
                .first_i      (lane_first),
                .cand_value_i (in_data[k*VALUE_WIDTH +: VALUE_WIDTH]),
                .cand_index_i (IDX_W'(lane_pos)),
                .max_value_i  (chain_value[k]),
                .max_index_i  (chain_index[k]),
`ifdef STREAM_ARGMAX_MARGIN_EN
                .sec_valid_i  (chain_sec_valid[k]),
                .sec_value_i  (chain_sec_value[k]),
                .sec_index_i  (chain_sec_index[k]),
                .sec_valid_o  (chain_sec_valid[k+1]),
                .sec_value_o  (chain_sec_value[k+1]),
                .sec_index_o  (chain_sec_index[k+1]),
`endif
                .max_value_o  (chain_value[k+1]),
                .max_index_o  (chain_index[k+1])
            );
        end
    endgenerate

    // Next-state: absorb accepted beats, publish on the final beat, release on output handshake.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        run_value_d = run_value_q;
        run_index_d = run_index_q;
        res_value_d = res_value_q;
        res_index_d = res_index_q;
`ifdef STREAM_ARGMAX_MARGIN_EN
        run_sec_valid_d = run_sec_valid_q;
        run_sec_value_d = run_sec_value_q;
        run_sec_index_d = run_sec_index_q;
        res_sec_index_d = res_sec_index_q;
        res_margin_d    = res_margin_q;
`endif
        if (accept) begin
            run_value_d = chain_value[LANES];
            run_index_d = chain_index[LANES];
`ifdef STREAM_ARGMAX_MARGIN_EN
            run_sec_valid_d = chain_sec_valid[LANES];
            run_sec_value_d = chain_sec_value[LANES];
            run_sec_index_d = chain_sec_index[LANES];
`endif
            if (last_beat) begin
                beat_d      = '0;
                state_d     = DONE;
                res_value_d = chain_value[LANES];
                res_index_d = chain_index[LANES];
`ifdef STREAM_ARGMAX_MARGIN_EN
                res_sec_index_d = chain_sec_index[LANES];
                res_margin_d    = margin_calc;
`endif
            end else begin
                beat_d = beat_q + CNT_W'(1);
            end
        end
        if (out_valid && out_ready) begin
            state_d = ACCUM;
        end
    end

    // State and result registers; reset drops any partial vector or pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            beat_q      <= '0;
            run_value_q <= '0;
            run_index_q <= '0;
            res_value_q <= '0;
            res_index_q <= '0;
`ifdef STREAM_ARGMAX_MARGIN_EN
            run_sec_valid_q <= 1'b0;
            run_sec_value_q <= '0;
            run_sec_index_q <= '0;
            res_sec_index_q <= '0;
            res_margin_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            run_value_q <= run_value_d;
            run_index_q <= run_index_d;
            res_value_q <= res_value_d;
            res_index_q <= res_index_d;
`ifdef STREAM_ARGMAX_MARGIN_EN
            run_sec_valid_q <= run_sec_valid_d;
            run_sec_value_q <= run_sec_value_d;
            run_sec_index_q <= run_sec_index_d;
            res_sec_index_q <= res_sec_index_d;
            res_margin_q    <= res_margin_d;
`endif
        end
    end

    assign out_index = res_index_q;
    assign out_value = res_value_q;
`ifdef STREAM_ARGMAX_MARGIN_EN
    assign out_second_index = res_sec_index_q;
    assign out_margin       = res_margin_q;
`endif

endmodule

// File: tb/tb_stream_argmax.sv
// tb/tb_stream_argmax.sv - self-checking bench for stream_argmax (unsigned 4-lane and signed single-beat instances)
module tb_stream_argmax;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       in_valid, in_ready, out_valid, out_ready;
    logic [127:0]     in_data_u;
    logic [319:0]     in_data_s;
    logic [1:0][3:0]  out_index;
    logic [1:0][31:0] out_value;
`ifdef STREAM_ARGMAX_MARGIN_EN
    logic [1:0][3:0]  out_second_index;
    logic [1:0][32:0] out_margin;
`endif

    int n_pass  = 0;
    int n_total = 0;

    stream_argmax #(.VALUE_WIDTH(32), .NUM_VALUES(10), .LANES(4), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data_u),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_index(out_index[0]), .out_value(out_value[0])
`ifdef STREAM_ARGMAX_MARGIN_EN
        , .out_second_index(out_second_index[0]), .out_margin(out_margin[0])
`endif
    );

    stream_argmax #(.VALUE_WIDTH(32), .NUM_VALUES(10), .LANES(10), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data_s),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_index(out_index[1]), .out_value(out_value[1])
`ifdef STREAM_ARGMAX_MARGIN_EN
        , .out_second_index(out_second_index[1]), .out_margin(out_margin[1])
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic gtm(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        return sgn ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    function automatic logic [31:0] lane_val(input int d, input int k);
        return (d == 0) ? in_data_u[k*32 +: 32] : in_data_s[k*32 +: 32];
    endfunction

    logic [31:0] col [2][10];
    int          col_n [2] = '{0, 0};
    logic [1:0]  pend = 2'b00;
    logic [3:0]  e_idx [2] = '{4'd0, 4'd0};
    logic [31:0] e_val [2] = '{32'd0, 32'd0};
`ifdef STREAM_ARGMAX_MARGIN_EN
    logic [3:0]  e_sec [2] = '{4'd0, 4'd0};
    logic [32:0] e_mar [2] = '{33'd0, 33'd0};
`endif

    // Whole-vector argmax: lowest index of the maximum; runner-up is the lowest index of the maximum of the rest.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend = 2'b00;
            for (int d = 0; d < 2; d++) begin
                col_n[d] = 0;
                e_idx[d] = '0;
                e_val[d] = '0;
`ifdef STREAM_ARGMAX_MARGIN_EN
                e_sec[d] = '0;
                e_mar[d] = '0;
`endif
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (pend[d]) begin
                    if (out_ready[d]) pend[d] = 1'b0;
                end else if (in_valid[d]) begin
                    for (int k = 0; k < ((d == 0) ? 4 : 10); k++) begin
                        if (col_n[d] < 10) begin
                            col[d][col_n[d]] = lane_val(d, k);
                            col_n[d]++;
                        end
                    end
                    if (col_n[d] == 10) begin
                        int b;
                        int s;
                        logic sg;
                        sg = (d == 1);
                        b  = 0;
                        s  = -1;
                        for (int i = 1; i < 10; i++) if (gtm(col[d][i], col[d][b], sg)) b = i;
                        for (int i = 0; i < 10; i++)
                            if (i != b && (s < 0 || gtm(col[d][i], col[d][s], sg))) s = i;
                        e_idx[d] = 4'(b);
                        e_val[d] = col[d][b];
`ifdef STREAM_ARGMAX_MARGIN_EN
                        e_sec[d] = 4'(s);
                        e_mar[d] = sg ? ({col[d][b][31], col[d][b]} - {col[d][s][31], col[d][s]})
                                      : ({1'b0, col[d][b]} - {1'b0, col[d][s]});
`endif
                        pend[d]  = 1'b1;
                        col_n[d] = 0;
                    end
                end
            end
        end
    end

    // Every cycle, both instances must agree with the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_in_ready", d), in_ready[d], !pend[d]);
            chk($sformatf("dut%0d_out_valid", d), out_valid[d], pend[d]);
            chk($sformatf("dut%0d_out_index", d), out_index[d], e_idx[d]);
            chk($sformatf("dut%0d_out_value", d), out_value[d], e_val[d]);
`ifdef STREAM_ARGMAX_MARGIN_EN
            chk($sformatf("dut%0d_out_second_index", d), out_second_index[d], e_sec[d]);
            chk($sformatf("dut%0d_out_margin", d), out_margin[d], e_mar[d]);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_accept(input int d);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready[d];
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_vec(input int d, input logic [31:0] v [10], input logic [31:0] pad);
        int ln;
        int nb;
        ln = (d == 0) ? 4 : 10;
        nb = (10 + ln - 1) / ln;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < ln; k++) begin
                logic [31:0] x;
                x = (b*ln + k < 10) ? v[b*ln + k] : pad;
                if (d == 0) in_data_u[k*32 +: 32] = x;
                else        in_data_s[k*32 +: 32] = x;
            end
            in_valid[d] = 1'b1;
            wait_accept(d);
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic take_result(input int d, input logic [3:0] idx, input logic [31:0] val,
                               input logic [3:0] sec, input logic [32:0] mar);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid[d];
        end
        chk("result_valid", seen, 1'b1);
        chk("result_index", out_index[d], idx);
        chk("result_value", out_value[d], val);
`ifdef STREAM_ARGMAX_MARGIN_EN
        chk("result_second_index", out_second_index[d], sec);
        chk("result_margin", out_margin[d], mar);
`else
        if (sec === 4'hx || mar === 33'hx) chk("result_args", 64'd0, 64'd1);
`endif
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
    endtask

    task automatic check_latency(input int d);
        @(negedge clk);
        chk("latency_out_valid", out_valid[d], 1'b1);
    endtask

    initial begin
        logic [31:0] v [10];
        logic [31:0] w [10];
        rst       = 1'b1;
        in_valid  = 2'b00;
        out_ready = 2'b00;
        in_data_u = '0;
        in_data_s = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready[0], 1'b1);
        chk("reset_out_valid", out_valid[0], 1'b0);
        chk("reset_out_index", out_index[0], 4'd0);
        chk("reset_out_value", out_value[0], 32'd0);
        rst = 1'b0;

        // Tie at index 3 loses to index 1.
        v = '{32'd3, 32'd9, 32'd1, 32'd9, 32'd0, 32'd2, 32'd7, 32'd5, 32'd8, 32'd4};
        send_vec(0, v, 32'd0);
        check_latency(0);
        take_result(0, 4'd1, 32'd9, 4'd3, 33'd0);

        // All-ones padding lanes on the last beat are ignored.
        v = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd6, 32'd5, 32'd1, 32'd2, 32'd0, 32'd3};
        send_vec(0, v, 32'hFFFF_FFFF);
        take_result(0, 4'd4, 32'd6, 4'd5, 33'd1);

        // Signed compare on a single-beat vector.
        v = '{-32'sd5, -32'sd2, -32'sd9, -32'sd2, -32'sd20, -32'sd20, -32'sd20, -32'sd20, -32'sd20, -32'sd20};
        send_vec(1, v, 32'd0);
        check_latency(1);
        take_result(1, 4'd1, 32'hFFFF_FFFE, 4'd3, 33'd0);

        // Output stall with the next beat already offered.
        v = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80, 32'd90, 32'd15};
        w = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4};
        send_vec(0, v, 32'd0);
        in_data_u   = {4{32'd4}};
        in_valid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready[0], 1'b0);
            chk("stall_out_valid", out_valid[0], 1'b1);
            chk("stall_out_index", out_index[0], 4'd8);
            chk("stall_out_value", out_value[0], 32'd90);
        end
        take_result(0, 4'd8, 32'd90, 4'd7, 33'd10);
        send_vec(0, w, 32'd0);
        take_result(0, 4'd0, 32'd4, 4'd1, 33'd0);

        // Reset after two of three beats discards the partial vector.
        in_data_u   = {4{32'd1000}};
        in_valid[0] = 1'b1;
        wait_accept(0);
        in_data_u   = {4{32'd2000}};
        wait_accept(0);
        in_valid[0] = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_in_ready", in_ready[0], 1'b1);
            chk("rstmid_out_valid", out_valid[0], 1'b0);
            chk("rstmid_out_index", out_index[0], 4'd0);
            chk("rstmid_out_value", out_value[0], 32'd0);
            chk("rstmid_s_out_value", out_value[1], 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        v = '{32'd7, 32'd3, 32'd7, 32'd11, 32'd2, 32'd11, 32'd0, 32'd1, 32'd5, 32'd6};
        send_vec(0, v, 32'd0);
        take_result(0, 4'd3, 32'd11, 4'd5, 33'd0);

        // Runner-up and margin vectors.
        v = '{32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        send_vec(0, v, 32'd0);
        take_result(0, 4'd0, 32'd5, 4'd1, 33'd5);
        v = '{32'd7, 32'd7, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        send_vec(0, v, 32'd0);
        take_result(0, 4'd0, 32'd7, 4'd1, 33'd0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/stream_argmax.md
# stream_argmax

Streaming, parametrised argmax unit for the CNN classifier output. It accepts a score vector of NUM_VALUES entries, LANES entries per beat, over a valid/ready handshake. It tracks the running maximum across beats and presents the winning index and value on a registered valid/ready output. It sits between the final dense layer and the class-decision logic, and supports wide or long score vectors that cannot be flattened into one bus.

## Interface
- VALUE_WIDTH, 32, bit width of one score
- NUM_VALUES, 10, entries per vector; must be ≥ 2
- LANES, 2, entries per input beat; 1 ≤ LANES ≤ NUM_VALUES
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare
- Derived: IDX_W = max(1, $clog2(NUM_VALUES)); NUM_BEATS = ceil(NUM_VALUES / LANES)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  block accepts a beat
- in_data  in  LANES*VALUE_WIDTH  lane k at [k*VALUE_WIDTH +: VALUE_WIDTH]; vector index = beat*LANES + k
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_index  out  IDX_W  index of maximum
- out_value  out  VALUE_WIDTH  maximum score
- out_second_index  out  IDX_W  runner-up index (STREAM_ARGMAX_MARGIN_EN only)
- out_margin  out  VALUE_WIDTH+1  out_value − runner-up value, unsigned, always ≥ 0 (STREAM_ARGMAX_MARGIN_EN only)

## Operation
- States: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
- A beat is accepted when in_valid && in_ready. The beat counter runs 0..NUM_BEATS-1.
- Lanes are folded in ascending index order through a combinational chain, starting from the running state.
  - On the first element of a vector (beat 0, lane 0), the running max is loaded unconditionally.
- An element replaces the max only if strictly greater. Ties therefore resolve to the lowest index, both within a beat and across beats.
- Padding lanes are ignored: on the final beat, lanes with index ≥ NUM_VALUES are not compared.
- Accepting the final beat causes the transition ACCUM→DONE. At the same time the result registers load and the beat counter clears to 0.
- DONE→ACCUM occurs when out_valid && out_ready. The result registers hold their values until the next final beat.
- Compare is signed when SIGNED=1 and unsigned otherwise. There is no saturation and no arithmetic on the values, except the margin.

## Timing
- Reset values: state ACCUM, counter 0, in_ready 1, out_valid 0, out_index 0, out_value 0, out_second_index 0, out_margin 0.
- Latency: out_valid rises on the cycle after the final beat is accepted.
- Throughput: one vector per NUM_BEATS+1 cycles, plus any out_ready stall. Input and output phases do not overlap.
- in_ready is a registered state decode, with no combinational path from out_ready.
- out_index, out_value and out_valid are stable while out_valid=1 && out_ready=0.
- A beat presented with in_valid during DONE is not accepted. The upstream block must hold it.
- Asserting rst mid-vector discards the partial vector. Asserting rst during DONE drops the pending result.
- LANES = NUM_VALUES gives a single-beat vector: out_valid follows each accepted beat by one cycle.

## Configuration
- Macro: STREAM_ARGMAX_MARGIN_EN.
- When defined:
  - A runner-up is tracked alongside the max, with a second_valid flag that is cleared on the first element.
  - When an element beats the max, the old max becomes the runner-up.
  - Otherwise, the element replaces the runner-up if second_valid=0 or the element is strictly greater than it.
  - out_second_index and out_margin are driven, and out_margin is computed in VALUE_WIDTH+1 bits.
- When undefined, those ports and registers do not exist.

## Structure
- Package argmax_pkg holds:
  - the state enum (ACCUM, DONE)
  - an IDX_W helper function
  - a signed/unsigned compare function `gt(a, b, signed_mode)`
- Sub-module argmax_step is one combinational compare/update cell. It takes the running state plus one candidate, and outputs the new running state, including the runner-up fields under the macro. stream_argmax instantiates LANES of these cells in a chain.

## Test plan
- NUM_VALUES=10, LANES=4, unsigned; vector 3,9,1,9,0,2,7,5,8,4 → out_index=1, out_value=9. The tie at index 3 loses. out_valid appears 1 cycle after the 3rd beat.
- Same configuration; the final beat carries 0xFFFFFFFF in padding lanes 2 and 3, with real maximum 6 at index 4 → out_index=4. Padding is ignored.
- SIGNED=1, vector −5,−2,−9,−2,…(rest −20) → out_index=1, out_value=−2.
- Hold out_ready=0 for 5 cycles with in_valid=1 → in_ready stays 0 and the outputs are stable. The next vector starts after the out_ready handshake.
- Assert rst after beat 1 of 3, then send a fresh vector → the result reflects only the fresh vector. All outputs read 0 during reset.
- MARGIN_EN; vector 5,0,0,… → out_second_index=1, out_margin=5. Vector 7,7,1,… → index 0, second 1, margin 0.
